feistel_cipher_iter: RTL
========================

// Module: feistel_cipher_iter
// PURPOSE
//  Iterative, parametrised Feistel block cipher; successor to the single-round 8-bit encrypt datapath.
//  Encrypts or decrypts one 2*HALF_W-bit block per transaction.
//  Runs ROUNDS rounds, one per clock, on a shared round-function instance.
//  Sits between a producer and a consumer, with valid/ready handshakes on both sides.
// PARAMETERS
//  HALF_W  4  width of each Feistel half; block and key are 2*HALF_W bits (HALF_W >= 2)
//  ROUNDS  4  number of Feistel rounds per block (1..2**HALF_W)
// PORTS
//  clock      in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  in_valid   in   1         producer offers in_data/in_key/in_mode
//  in_ready   out  1         block can accept a new transaction
//  in_data    in   2*HALF_W  plaintext (mode 0) or ciphertext (mode 1)
//  in_key     in   2*HALF_W  cipher key
//  in_mode    in   1         0 = encrypt, 1 = decrypt
//  out_valid  out  1         out_data holds a finished result
//  out_ready  in   1         consumer accepts out_data
//  out_data   out  2*HALF_W  result block
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, in_ready=1, out_valid=0, out_data=0, round count=0, L=R=0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid: latch L=in_data[2H-1:H], R=in_data[H-1:0], key and mode;
//      cnt=0; go to RUN.
//    RUN: in_ready=0. Each cycle does one round: (L,R) <= (R, L ^ F(R, k_r)); cnt++.
//      After the round with cnt==ROUNDS-1: out_data <= {R_new, L_new} (final swap);
//      out_valid <= 1; go to DONE.
//    DONE: out_valid=1; out_data stable until out_ready. On out_ready: out_valid <= 0, go to IDLE.
//  - Latency: accept on edge T; out_valid=1 after edge T+ROUNDS. Throughput: one block per ROUNDS+2 cycles.
//  - in_ready is 0 in RUN and DONE; no accept overlaps an in-flight block.
//    in_valid while not ready is ignored.
//  - Round key: enc uses k_r = rotl(key, r); dec uses k_r = rotl(key, ROUNDS-1-r), r = cnt.
//    With this key order, decrypt(encrypt(x)) == x.
//  - F(R,k), all widths mod 2**HALF_W:
//    E = expand(R), 2H bits: E[2i] = R[i], E[2i+1] = R[(i+1) % H];
//    X = E ^ k;
//    F = X[2H-1:H] + X[H-1:0] + k[0]; carry out is discarded.
//  - Key and mode are sampled only at accept; later changes on the inputs have no effect on the block in flight.
//  - Reset asserted mid-RUN or mid-DONE: the block is dropped, out_valid=0 immediately, no partial output.
//  - out_ready while out_valid=0 has no effect.
// STRUCTURE
//  - Shared include feistel_defs.vh holds:
//    - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
//    - MODE_ENC=1'b0, MODE_DEC=1'b1;
//    - the clog2 helper function for the cnt width.
//  - One sub-module, feistel_round_f(HALF_W): combinational inputs R and k, output F.
//    It contains the expansion, XOR and modular add.
//  - Top level holds the FSM, L/R/key/mode/cnt registers, round-key rotate mux and output register.
// TESTING
//  1. HALF_W=4, ROUNDS=4: in_data=8'h00, key=8'h00, mode=0 -> out_data=8'h00, out_valid exactly 4 cycles after accept.
//  2. HALF_W=4, ROUNDS=1: in_data=8'h46, key=8'h93, mode=0 -> out_data=8'h26.
//     Then in_data=8'h26, same key, mode=1 -> out_data=8'h46.
//  3. HALF_W=4, ROUNDS=4 and HALF_W=8, ROUNDS=6: 200 random (data,key) pairs, encrypt then decrypt.
//     Required: result == original every time; in_ready=0 throughout RUN/DONE.
//  4. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
//     Required: out_data stable, in_ready=0, a second in_valid ignored.
//     Raise out_ready -> in_ready=1 the next cycle.
//  5. Drive in_key/in_mode to new values during RUN.
//     Required: result equals the one computed with the values sampled at accept.
//  6. Assert reset for 1 cycle at round 2 of 4.
//     Required: out_valid=0 and in_ready=1 immediately; the next transaction completes normally with correct data.

Source files
------------

// File: rtl/feistel_cipher_iter_pkg.sv
// ---------------------------------------------------------------------------
// feistel_cipher_iter_pkg
//   Shared definitions for the iterative Feistel cipher: FSM state encoding,
//   mode encoding and the width helpers used to size the round counter.
// ---------------------------------------------------------------------------
package feistel_cipher_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Number of bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

    // The round counter is at least one bit wide, even for a single round.
    function automatic int cnt_width(input int rounds);
        return (clog2(rounds) < 1) ? 1 : clog2(rounds);
    endfunction

endpackage

// File: rtl/feistel_round_f.sv
// ---------------------------------------------------------------------------
// feistel_round_f
//   Combinational Feistel round function F(R, k).
//   Ports:
//     right      in   HALF_W    right half of the current block
//     round_key  in   2*HALF_W  key for this round
//     f_out      out  HALF_W    round function result
//   R is expanded to 2*HALF_W bits by pairing each bit with its upper
//   neighbour (wrapping), mixed with the round key, and the two halves of
//   the mix are added together with the key LSB; the carry out is dropped.
// ---------------------------------------------------------------------------
module feistel_round_f #(
    parameter int HALF_W = 4
) (
    input  logic [HALF_W-1:0]   right,
    input  logic [2*HALF_W-1:0] round_key,
    output logic [HALF_W-1:0]   f_out
);

    logic [2*HALF_W-1:0] expanded;
    logic [2*HALF_W-1:0] mixed;

    // NOTE: every signal written in always_comb gets a value before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        expanded = '0;
        for (int i = 0; i < HALF_W; i++) begin
            expanded[2*i]   = right[i];
            expanded[2*i+1] = right[(i + 1) % HALF_W];
        end
        mixed = expanded ^ round_key;
        f_out = mixed[2*HALF_W-1:HALF_W] + mixed[HALF_W-1:0]
              + HALF_W'(round_key[0]);
    end

endmodule

// File: rtl/feistel_cipher_iter.sv
// ---------------------------------------------------------------------------
// feistel_cipher_iter
//   Iterative Feistel block cipher: one round per clock on a single shared
//   round-function instance, ROUNDS rounds per 2*HALF_W-bit block.
//   Ports:
//     clock      in   1         rising-edge clock
//     reset      in   1         asynchronous, active-low reset
//     in_valid   in   1         producer offers in_data/in_key/in_mode
//     in_ready   out  1         high only while idle
//     in_data    in   2*HALF_W  plaintext (encrypt) or ciphertext (decrypt)
//     in_key     in   2*HALF_W  cipher key
//     in_mode    in   1         0 = encrypt, 1 = decrypt
//     out_valid  out  1         out_data holds a finished result
//     out_ready  in   1         consumer takes out_data
//     out_data   out  2*HALF_W  result block
//   Key and mode are captured at accept, so the inputs may change freely
//   while a block is in flight.
// ---------------------------------------------------------------------------
module feistel_cipher_iter
    import feistel_cipher_iter_pkg::*;
#(
    parameter int HALF_W = 4,
    parameter int ROUNDS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*HALF_W-1:0] in_data,
    input  logic [2*HALF_W-1:0] in_key,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_data
);

    localparam int BLK_W = 2 * HALF_W;
    localparam int CNT_W = cnt_width(ROUNDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

    state_t state;
    state_t state_next;

    logic [HALF_W-1:0] l_half;
    logic [HALF_W-1:0] r_half;
    logic [BLK_W-1:0]  key_latched;
    logic              mode_latched;
    logic [CNT_W-1:0]  cnt;
    logic [BLK_W-1:0]  out_data_reg;

    logic [CNT_W-1:0]   round_idx;
    int                 rot_amt;
    logic [2*BLK_W-1:0] key_twice;
    logic [BLK_W-1:0]   round_key;
    logic [HALF_W-1:0]  f_val;
    logic               last_round;

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign out_data   = out_data_reg;
    assign last_round = (cnt == LAST_CNT);

    // Decryption walks the key schedule backwards so it undoes encryption.
    // The rotate is taken from a doubled key: the low BLK_W bits of
    // {key,key} >> (BLK_W - n) are key rotated left by n.
    always_comb begin
        round_idx = (mode_latched == MODE_DEC) ? (LAST_CNT - cnt) : cnt;
        rot_amt   = int'(round_idx) % BLK_W;
        key_twice = {key_latched, key_latched};
        round_key = BLK_W'(key_twice >> (BLK_W - rot_amt));
    end

    feistel_round_f #(
        .HALF_W(HALF_W)
    ) u_round_f (
        .right     (r_half),
        .round_key (round_key),
        .f_out     (f_val)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)   state_next = ST_RUN;
            ST_RUN:  if (last_round) state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // NOTE: these are plain registers (no memory array), so all of them are
    // cleared by reset; a dropped block leaves nothing stale behind.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            l_half       <= '0;
            r_half       <= '0;
            key_latched  <= '0;
            mode_latched <= MODE_ENC;
            cnt          <= '0;
            out_data_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        l_half       <= in_data[BLK_W-1:HALF_W];
                        r_half       <= in_data[HALF_W-1:0];
                        key_latched  <= in_key;
                        mode_latched <= in_mode;
                        cnt          <= '0;
                    end
                end
                ST_RUN: begin
                    l_half <= r_half;
                    r_half <= l_half ^ f_val;
                    cnt    <= cnt + 1'b1;
                    // The last round's halves are emitted swapped back.
                    if (last_round) begin
                        out_data_reg <= {l_half ^ f_val, r_half};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
